// File: rtl/id_inst_queue_if.sv
// IF->ID handshake bundle for the instruction queue: push side from IF,
// pop side toward ID, plus the occupancy count.
interface id_inst_queue_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_inst;
    logic              out_ready;
    logic [ADDR_W:0]   count;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/id_inst_queue.sv
// DEPTH-entry circular FIFO of {pc, inst} between IF and ID with synchronous flush.
// Define ID_INST_QUEUE_BYPASS_EN for a zero-latency in->out path when empty and ID is ready.
module id_inst_queue #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    id_inst_queue_if.slave    q
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];

    logic empty, full, push, pop, bypass;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
`ifdef ID_INST_QUEUE_BYPASS_EN
        bypass = empty & q.in_valid & q.out_ready & ~flush;
`else
        bypass = 1'b0;
`endif
        // A bypassed entry is consumed directly, so it never occupies storage.
        push = q.in_valid & ~full & ~bypass & ~flush;
        pop  = ~empty & q.out_ready & ~flush;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale contents stay hidden behind the empty gate.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q[ADDR_W-1:0]]   <= q.in_pc;
            inst_mem_q[wr_ptr_q[ADDR_W-1:0]] <= q.in_inst;
        end
    end

    always_comb begin
        q.in_ready  = ~full;
        q.count     = wr_ptr_q - rd_ptr_q;
        q.out_valid = ~empty;
        q.out_pc    = '0;
        q.out_inst  = '0;
        if (!empty) begin
            q.out_pc   = pc_mem_q[rd_ptr_q[ADDR_W-1:0]];
            q.out_inst = inst_mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
        if (bypass) begin
            q.out_valid = 1'b1;
            q.out_pc    = q.in_pc;
            q.out_inst  = q.in_inst;
        end
    end
endmodule

// File: tb/tb_id_inst_queue.sv
// Randomized scoreboard bench for id_inst_queue; reference is an ordered list of
// accepted instructions, each tagged with the cycle it becomes visible to ID.
module tb_id_inst_queue;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          vis;
        bit          byp;
    } ent_t;

    logic clk, rst, flush;
    int   cyc;
    bit   run;
    int   n_cmp, n_err;
    ent_t sb[$];

    id_inst_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    id_inst_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .q     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drives one cycle of stimulus and records what the queue is expected to accept.
    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit ordy, input bit fl);
        ent_t e;
        @(posedge clk);
        #2;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        flush         = fl;
        e.pc   = pc;
        e.inst = inst;
        e.vis  = cyc + 1;
        e.byp  = 1'b0;
        if (!fl && v) begin
`ifdef ID_INST_QUEUE_BYPASS_EN
            if (ordy && sb.size() == 0) begin
                e.byp = 1'b1;
                e.vis = cyc;
            end
`endif
            if (e.byp || sb.size() < DEPTH) sb.push_back(e);
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, '0, ordy, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        int          n, ec;
        logic [31:0] ep, ei;
        if (run && !rst) begin
            n  = 0;
            ec = 0;
            foreach (sb[i]) begin
                if (sb[i].vis <= cyc) begin
                    n++;
                    if (!sb[i].byp) ec++;
                end
            end
            ep = (n > 0) ? sb[0].pc   : 32'h0;
            ei = (n > 0) ? sb[0].inst : 32'h0;
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, n > 0});
            chk("out_pc",    bus.out_pc,   ep);
            chk("out_inst",  bus.out_inst, ei);
            chk("count",     {29'b0, bus.count}, ec);
            chk("in_ready",  {31'b0, bus.in_ready}, {31'b0, ec < DEPTH});
            if (flush) sb.delete();
            else if (n > 0 && bus.out_ready) void'(sb.pop_front());
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'h0);
        chk({tag, "_out_pc"},    bus.out_pc,   32'h0);
        chk({tag, "_out_inst"},  bus.out_inst, 32'h0);
        chk({tag, "_count"},     {29'b0, bus.count}, 32'h0);
        chk({tag, "_in_ready"},  {31'b0, bus.in_ready}, 32'h1);
    endtask

    initial begin
        cyc = 0; run = 1'b0; n_cmp = 0; n_err = 0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
        #12;
        reset_checks("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        run = 1'b1;

        // First fetch after reset, held by a stalled ID.
        step(1'b1, 32'hBFC0_0000, 32'h3C01_0001, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to DEPTH, offer a fifth entry while full, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
        step(1'b1, 32'h10, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        // Streaming push+pop; pointers wrap past 2*DEPTH.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Flush with three held entries and an in-flight fetch.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-cycle with two entries held.
        step(1'b1, 32'h400, $urandom, 1'b0, 1'b0);
        step(1'b1, 32'h404, $urandom, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Empty queue with ID ready: same-cycle with bypass, one cycle later without.
        idle(1'b1);
        step(1'b1, 32'h500, 32'h2402_0005, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction buffer between the IF and ID stages.
- Replaces the single-entry stall buffer (is_stop / buf_inst) with a DEPTH-entry circular FIFO of {pc, inst} pairs.
- Uses a valid/ready handshake on both sides and a synchronous flush for branch redirect.
- ID consumes the head entry. When the queue is empty, ID receives a zero bubble (pc=0, inst=0), the same as ce=0 today.

Parameters:
- DATA_W, 32, instruction width in bits
- PC_W, 32, PC width in bits
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, $clog2(DEPTH), local only, pointer index width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  discard all entries (branch taken / exception redirect)
- in_valid  in  1  IF presents a fetched instruction
- in_pc  in  PC_W  PC of the fetched instruction
- in_inst  in  DATA_W  inst_sram_rdata for that PC
- in_ready  out  1  queue can accept an entry this cycle
- out_valid  out  1  head entry valid toward ID
- out_pc  out  PC_W  head PC; 0 when out_valid=0
- out_inst  out  DATA_W  head instruction; 0 when out_valid=0
- out_ready  in  1  ID advances this cycle (stall[2]==NoStop)
- count  out  ADDR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Pointers and state:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide and wrap modulo 2*DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the low ADDR_W bits are equal.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = ~full. It is combinational from state only and never depends on out_ready.
  - A pop while full does not enable a push in the same cycle.
- Outputs:
  - out_valid = ~empty.
  - out_pc and out_inst come from storage[rd_ptr[ADDR_W-1:0]], gated to 0 when empty.
- Latency: an entry pushed in cycle N appears at the outputs in cycle N+1 (without the bypass feature).
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- Push when empty: count 0 -> 1; out_valid rises the next cycle.
- Pop of the last entry with no push: out_valid=0 and outputs 0 the next cycle.
- Flush is synchronous and has highest priority:
  - In the flush cycle, push and pop are both ignored; the input instruction is dropped.
  - Next cycle: wr_ptr = rd_ptr = 0, count = 0, out_valid = 0.
  - During the flush cycle, in_ready still reflects the current state.
- Reset (asynchronous, any time, including mid-stream):
  - Pointers and count go to 0 immediately; out_valid=0, out_pc=0, out_inst=0, in_ready=1.
  - Storage contents are not reset; they are masked by empty.
- Storage is written only on push; no read-modify of the other entries.
- count always equals wr_ptr - rd_ptr modulo 2*DEPTH and never exceeds DEPTH.

Optional Feature:
- Macro: ID_INST_QUEUE_BYPASS_EN.
- Defined: when empty & in_valid & out_ready & ~flush, the input passes combinationally to the outputs.
  - out_valid=1, out_pc=in_pc, out_inst=in_inst.
  - The entry is consumed without being written; pointers and count stay unchanged.
  - Zero-latency path for an unstalled pipeline.
  - When empty but out_ready=0, the entry is written normally.
- Not defined: no combinational in->out path; minimum latency is 1 cycle.

Test Plan:
- Reset, then push pc=0xBFC00000 inst=0x3C010001 with out_ready=0 -> next cycle out_valid=1, out_pc=0xBFC00000, out_inst=0x3C010001, count=1.
- DEPTH=4, out_ready=0, push pcs 0x00,0x04,0x08,0x0C -> count=4, in_ready=0; a 5th in_valid (pc 0x10) is not stored; raise out_ready -> pops return 0x00,0x04,0x08,0x0C in order, then out_valid=0, out_pc=0.
- Continuous push and pop, 10 entries through a 4-deep queue -> count holds at 1 and pointers wrap past 2*DEPTH; output order equals input order with no loss or duplication.
- Queue holding 3 entries; assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the in-flight instruction is absent from later outputs.
- Assert rst asynchronously mid-cycle with count=2 -> out_valid, out_pc, out_inst and count go to 0 before the next clk edge; in_ready=1.
- With ID_INST_QUEUE_BYPASS_EN: empty queue, in_valid=1, out_ready=1, in_inst=0x24020005 -> same-cycle out_valid=1, out_inst=0x24020005, count stays 0. Without the macro: out_valid=0 that cycle and count=1 afterward.
